// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default width, branch compare codes and
// control-transfer kinds.
package riscv_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      CMP_EQ  = 3'b000,
      CMP_NE  = 3'b001,
      CMP_LT  = 3'b100,
      CMP_GE  = 3'b101,
      CMP_LTU = 3'b110,
      CMP_GEU = 3'b111
   } cmp_e;

   typedef enum logic [1:0] {
      KIND_BRANCH = 2'b00,
      KIND_JAL    = 2'b01,
      KIND_JALR   = 2'b10,
      KIND_RSVD   = 2'b11
   } kind_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle between the operand muxes, the resolve unit and the
// fetch redirect logic.
interface branch_resolve_unit_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_0;
   logic [XLEN-1:0]  in_1;
   logic [2:0]       mode;
   logic [1:0]       kind;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  imm;
   logic             pred_taken;
   logic [XLEN-1:0]  pred_target;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic             taken;
   logic [XLEN-1:0]  target;
   logic             mispredict;
   logic             illegal_mode;
   logic [CNT_W-1:0] n_branches;
   logic [CNT_W-1:0] n_mispredicts;

   modport master (
      output in_valid, in_0, in_1, mode, kind, pc, imm, pred_taken, pred_target,
             flush, out_ready,
      input  in_ready, out_valid, taken, target, mispredict, illegal_mode,
             n_branches, n_mispredicts
   );

   modport slave (
      input  in_valid, in_0, in_1, mode, kind, pc, imm, pred_taken, pred_target,
             flush, out_ready,
      output in_ready, out_valid, taken, target, mispredict, illegal_mode,
             n_branches, n_mispredicts
   );
endinterface

// File: rtl/branch_cmp.sv
// Combinational branch comparator: funct3 mode and operands to direction,
// flagging the two unassigned mode encodings.
module branch_cmp
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [2:0]      mode,
   input  logic [XLEN-1:0] in_0,
   input  logic [XLEN-1:0] in_1,
   output logic            taken_c,
   output logic            illegal_c
);

   always_comb begin
      taken_c   = 1'b0;
      illegal_c = 1'b0;
      case (mode)
         CMP_EQ:  taken_c = (in_0 == in_1);
         CMP_NE:  taken_c = (in_0 != in_1);
         CMP_LT:  taken_c = ($signed(in_0) <  $signed(in_1));
         CMP_GE:  taken_c = ($signed(in_0) >= $signed(in_1));
         CMP_LTU: taken_c = (in_0 <  in_1);
         CMP_GEU: taken_c = (in_0 >= in_1);
         default: illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolver: direction, target and mispredict check with
// valid/ready flow control, flush and retire statistics.
module branch_resolve_unit
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEFAULT,
   parameter int unsigned STAGES = 1,
   parameter int unsigned CNT_W  = 32
) (
   input logic                  clk,
   input logic                  res_n,
   branch_resolve_unit_if.slave bus
);

   typedef struct packed {
      logic            taken;
      logic            illegal;
      logic [XLEN-1:0] target;
      logic            pred_taken;
      logic [XLEN-1:0] pred_target;
   } res_t;

   typedef struct packed {
      logic            taken;
      logic            illegal;
      logic            mispredict;
      logic [XLEN-1:0] target;
   } out_t;

   function automatic out_t check_pred(input res_t r);
      out_t o;
      o.taken      = r.taken;
      o.illegal    = r.illegal;
      o.target     = r.target;
      o.mispredict = (r.taken != r.pred_taken) | (r.taken & (r.target != r.pred_target));
      return o;
   endfunction

   logic       cmp_taken_c;
   logic       cmp_illegal_c;
   res_t       res_c;
   out_t       stage_out;
   logic       out_vld;
   logic       in_ready_c;
   logic       accept;
   logic       retire;
   logic [CNT_W-1:0] n_br_q, n_br_d, n_mp_q, n_mp_d;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .mode      (bus.mode),
      .in_0      (bus.in_0),
      .in_1      (bus.in_1),
      .taken_c   (cmp_taken_c),
      .illegal_c (cmp_illegal_c)
   );

   // Resolve direction and next PC for the offered transaction.
   always_comb begin
      res_c             = '0;
      res_c.pred_taken  = bus.pred_taken;
      res_c.pred_target = bus.pred_target;
      case (bus.kind)
         KIND_BRANCH: begin
            res_c.taken   = cmp_taken_c;
            res_c.illegal = cmp_illegal_c;
         end
         KIND_JAL, KIND_JALR: res_c.taken = 1'b1;
         default:             res_c.taken = 1'b0;
      endcase
      if (!res_c.taken)
         res_c.target = bus.pc + XLEN'(4);
      else if (bus.kind == KIND_JALR)
         res_c.target = (bus.in_0 + bus.imm) & ~XLEN'(1);
      else
         res_c.target = bus.pc + bus.imm;
   end

   assign accept = bus.in_valid & in_ready_c;
   assign retire = out_vld & bus.out_ready;

   if (STAGES == 1) begin : g_one
      logic s1_valid_q, s1_valid_d;
      out_t s1_q, s1_d;

      assign in_ready_c = ~s1_valid_q | bus.out_ready;

      always_comb begin
         s1_valid_d = s1_valid_q;
         s1_d       = s1_q;
         if (retire) s1_valid_d = 1'b0;
         if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = check_pred(res_c);
         end
         if (bus.flush) s1_valid_d = 1'b0;
      end

      always_ff @(posedge clk or negedge res_n) begin
         if (!res_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
         end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
         end
      end

      assign out_vld   = s1_valid_q;
      assign stage_out = s1_q;
   end else if (STAGES == 2) begin : g_two
      logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
      res_t s1_q, s1_d;
      out_t s2_q, s2_d;
      logic s2_load;

      // Stage 1 moves forward whenever stage 2 is empty or draining.
      assign s2_load    = s1_valid_q & (~s2_valid_q | bus.out_ready);
      assign in_ready_c = ~s1_valid_q | s2_load;

      always_comb begin
         s1_valid_d = s1_valid_q;
         s1_d       = s1_q;
         s2_valid_d = s2_valid_q;
         s2_d       = s2_q;
         if (s2_load) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b1;
            s2_d       = check_pred(s1_q);
         end else if (retire) begin
            s2_valid_d = 1'b0;
         end
         if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = res_c;
         end
         if (bus.flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge res_n) begin
         if (!res_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
         end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
         end
      end

      assign out_vld   = s2_valid_q;
      assign stage_out = s2_q;
   end else begin : g_bad
      $error("branch_resolve_unit: STAGES must be 1 or 2");
   end

   // Statistics advance only when a result is consumed.
   always_comb begin
      n_br_d = n_br_q;
      n_mp_d = n_mp_q;
      if (retire) begin
         n_br_d = n_br_q + CNT_W'(1);
         n_mp_d = n_mp_q + CNT_W'(stage_out.mispredict);
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         n_br_q <= '0;
         n_mp_q <= '0;
      end else begin
         n_br_q <= n_br_d;
         n_mp_q <= n_mp_d;
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.out_valid     = out_vld;
   assign bus.taken         = stage_out.taken;
   assign bus.target        = stage_out.target;
   assign bus.mispredict    = stage_out.mispredict;
   assign bus.illegal_mode  = stage_out.illegal;
   assign bus.n_branches    = n_br_q;
   assign bus.n_mispredicts = n_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (two-stage build): directed vectors
// with hand-computed results, stall, flush and mid-stream reset.
module tb_branch_resolve_unit;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned STAGES = 2;
   localparam int unsigned CNT_W  = 32;

   typedef struct {
      logic [2:0]  mode;
      logic [1:0]  kind;
      logic [31:0] a, b, pc, imm;
      logic        pt;
      logic [31:0] ptg;
      logic        e_taken;
      logic [31:0] e_tgt;
      logic        e_mp;
      logic        e_ill;
   } vec_t;

   logic clk;
   logic res_n;
   vec_t tbl [14];
   int   exp_q [$];
   int   n_vec;
   int   n_mis;

   branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   branch_resolve_unit #(.XLEN(XLEN), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] mode, input logic [1:0] kind,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic pt, input logic [31:0] ptg,
                               input logic et, input logic [31:0] etg,
                               input logic emp, input logic eill);
      vec_t v;
      v.mode = mode; v.kind = kind; v.a = a; v.b = b; v.pc = pc; v.imm = imm;
      v.pt = pt; v.ptg = ptg; v.e_taken = et; v.e_tgt = etg; v.e_mp = emp; v.e_ill = eill;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Offer one table entry and queue its expected result once accepted.
   task automatic send(input int idx);
      int   k;
      logic rdy;
      bus.in_valid    = 1'b1;
      bus.mode        = tbl[idx].mode;
      bus.kind        = tbl[idx].kind;
      bus.in_0        = tbl[idx].a;
      bus.in_1        = tbl[idx].b;
      bus.pc          = tbl[idx].pc;
      bus.imm         = tbl[idx].imm;
      bus.pred_taken  = tbl[idx].pt;
      bus.pred_target = tbl[idx].ptg;
      k   = 0;
      rdy = 1'b0;
      while (!rdy && k < 50) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         k++;
      end
      chk($sformatf("accept[%0d]", idx), 64'(rdy), 64'd1);
      if (rdy) exp_q.push_back(idx);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the head entry whenever a result is presented (held
   // results are re-checked every stalled cycle); pop on retire.
   always @(negedge clk) begin
      if (res_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_output: got target 0x%0h with nothing outstanding", bus.target);
         end else begin
            chk($sformatf("out[%0d] {taken,ill,mp,target}", exp_q[0]),
                64'({bus.taken, bus.illegal_mode, bus.mispredict, bus.target}),
                64'({tbl[exp_q[0]].e_taken, tbl[exp_q[0]].e_ill, tbl[exp_q[0]].e_mp, tbl[exp_q[0]].e_tgt}));
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      n_vec = 0;
      n_mis = 0;
      //           mode    kind  a             b             pc            imm           pt    ptg           taken tgt           mp    ill
      tbl[0]  = mk(3'b000, 2'd0, 32'h5,        32'h5,        32'h100,      32'h20,       1'b0, 32'h0,        1'b1, 32'h120,      1'b1, 1'b0);
      tbl[1]  = mk(3'b100, 2'd0, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1'b1, 32'h240,      1'b1, 32'h240,      1'b0, 1'b0);
      tbl[2]  = mk(3'b110, 2'd0, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1'b1, 32'h240,      1'b0, 32'h204,      1'b1, 1'b0);
      tbl[3]  = mk(3'b111, 2'd0, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       1'b0, 32'h0,        1'b1, 32'h240,      1'b1, 1'b0);
      tbl[4]  = mk(3'b000, 2'd2, 32'h1001,     32'h0,        32'h300,      32'h2,        1'b1, 32'h1002,     1'b1, 32'h1002,     1'b0, 1'b0);
      tbl[5]  = mk(3'b000, 2'd1, 32'h0,        32'h0,        32'h400,      32'hFFFFFFF0, 1'b1, 32'h3F4,      1'b1, 32'h3F0,      1'b1, 1'b0);
      tbl[6]  = mk(3'b000, 2'd1, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h8,        1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 1'b0);
      tbl[7]  = mk(3'b001, 2'd0, 32'h3,        32'h4,        32'h600,      32'hFFFFFFFC, 1'b1, 32'h5FC,      1'b1, 32'h5FC,      1'b0, 1'b0);
      tbl[8]  = mk(3'b101, 2'd0, 32'h80000000, 32'h7FFFFFFF, 32'h700,      32'h10,       1'b0, 32'h0,        1'b0, 32'h704,      1'b0, 1'b0);
      tbl[9]  = mk(3'b000, 2'd3, 32'h0,        32'h0,        32'h800,      32'h10,       1'b0, 32'h0,        1'b0, 32'h804,      1'b0, 1'b0);
      tbl[10] = mk(3'b010, 2'd0, 32'h0,        32'h0,        32'h500,      32'h8,        1'b1, 32'h508,      1'b0, 32'h504,      1'b1, 1'b1);
      tbl[11] = mk(3'b011, 2'd0, 32'h0,        32'h0,        32'h510,      32'h8,        1'b0, 32'h0,        1'b0, 32'h514,      1'b0, 1'b1);
      tbl[12] = mk(3'b000, 2'd0, 32'h1,        32'h2,        32'h900,      32'h40,       1'b0, 32'h0,        1'b0, 32'h904,      1'b0, 1'b0);
      tbl[13] = mk(3'b011, 2'd1, 32'h0,        32'h0,        32'hA00,      32'h100,      1'b1, 32'hB00,      1'b1, 32'hB00,      1'b0, 1'b0);

      bus.in_valid = 1'b0; bus.mode = '0; bus.kind = '0; bus.in_0 = '0; bus.in_1 = '0;
      bus.pc = '0; bus.imm = '0; bus.pred_taken = 1'b0; bus.pred_target = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
      res_n = 1'b1;
      #2 res_n = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid",  64'(bus.out_valid),     64'd0);
      chk("rst_taken",      64'(bus.taken),         64'd0);
      chk("rst_target",     64'(bus.target),        64'd0);
      chk("rst_mispredict", 64'(bus.mispredict),    64'd0);
      chk("rst_illegal",    64'(bus.illegal_mode),  64'd0);
      chk("rst_n_branches", 64'(bus.n_branches),    64'd0);
      chk("rst_n_mispred",  64'(bus.n_mispredicts), 64'd0);
      @(posedge clk);
      #1 res_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // BEQ latency: result appears STAGES cycles after the accept cycle
      send(0);
      for (int i = 0; i < int'(STAGES) - 1; i++) begin
         @(negedge clk);
         chk("lat_early_valid", 64'(bus.out_valid), 64'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("lat_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      drain();

      // Remaining directed vectors, back to back
      for (int i = 1; i < 14; i++) send(i);
      drain();
      chk("cnt_branches_a", 64'(bus.n_branches),    64'd14);
      chk("cnt_mispred_a",  64'(bus.n_mispredicts), 64'd6);

      // 8 back-to-back with a 3-cycle consumer stall mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) send(i);
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("cnt_branches_b", 64'(bus.n_branches),    64'd22);
      chk("cnt_mispred_b",  64'(bus.n_mispredicts), 64'd11);

      // Flush with two transactions in flight
      bus.out_ready = 1'b0;
      send(1);
      send(2);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("flush_out_valid", 64'(bus.out_valid),     64'd0);
      chk("flush_in_ready",  64'(bus.in_ready),      64'd1);
      chk("flush_branches",  64'(bus.n_branches),    64'd22);
      chk("flush_mispred",   64'(bus.n_mispredicts), 64'd11);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;

      // Reset pulse with a result held at the output
      bus.out_ready = 1'b0;
      send(4);
      send(5);
      #2 res_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_out_valid",  64'(bus.out_valid),     64'd0);
      chk("mid_rst_taken",      64'(bus.taken),         64'd0);
      chk("mid_rst_target",     64'(bus.target),        64'd0);
      chk("mid_rst_mispredict", 64'(bus.mispredict),    64'd0);
      chk("mid_rst_branches",   64'(bus.n_branches),    64'd0);
      chk("mid_rst_mispred",    64'(bus.n_mispredicts), 64'd0);
      @(posedge clk);
      #1;
      res_n = 1'b1;
      bus.out_ready = 1'b1;

      // Illegal mode after reset
      send(10);
      drain();
      chk("cnt_branches_c", 64'(bus.n_branches),    64'd1);
      chk("cnt_mispred_c",  64'(bus.n_mispredicts), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
